// File: rtl/tx_fifo_pkg.sv
// tx_fifo_pkg: shared PIO defaults for the tx/rx word FIFOs.
package tx_fifo_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int DEPTH_DEF = 4;
   function automatic int lvl_w(input int depth);
      return $clog2(2 * depth) + 1;
   endfunction
endpackage

// File: rtl/tx_fifo_if.sv
// tx_fifo_if: system-write / state-machine-read FIFO port bundle.
interface tx_fifo_if import tx_fifo_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
);
   localparam int LW = lvl_w(DEPTH);
   logic             sys_push;
   logic [WIDTH-1:0] sys_wdata;
   logic             fsm_pull;
   logic [WIDTH-1:0] fsm_rdata;
   logic             fsm_stall;
   logic             join_mode;
   logic             flush;
   logic             full;
   logic             empty;
   logic [LW-1:0]    level;
   logic             txover;
   logic             txover_clr;
   modport master (
      output sys_push, sys_wdata, fsm_pull, join_mode, flush, txover_clr,
      input  fsm_rdata, fsm_stall, full, empty, level, txover
   );
   modport slave (
      input  sys_push, sys_wdata, fsm_pull, join_mode, flush, txover_clr,
      output fsm_rdata, fsm_stall, full, empty, level, txover
   );
endinterface

// File: rtl/tx_fifo.sv
// tx_fifo: show-ahead word FIFO, capacity DEPTH or 2*DEPTH (join_mode), sticky overflow flag.
module tx_fifo import tx_fifo_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input logic      clk,
   input logic      rst,
   tx_fifo_if.slave bus
);
   localparam int AW = $clog2(2 * DEPTH);
   localparam int LW = lvl_w(DEPTH);
   logic [WIDTH-1:0] mem_q [2*DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LW-1:0]    level_q, level_d, cap;
   logic             txover_q, txover_d, join_q, join_d;
   logic             push_ok, pull_ok, clr, full, empty;
   always_comb begin
      cap      = join_q ? LW'(2 * DEPTH) : LW'(DEPTH);
      full     = level_q == cap;
      empty    = level_q == '0;
      push_ok  = bus.sys_push & (!full | bus.fsm_pull);
      pull_ok  = bus.fsm_pull & !empty;
      // a change of join_mode repartitions storage, so it clears like flush
      clr      = bus.flush | (bus.join_mode != join_q);
      wptr_d   = clr ? '0 : wptr_q + AW'(push_ok);
      rptr_d   = clr ? '0 : rptr_q + AW'(pull_ok);
      level_d  = clr ? '0 : level_q + LW'(push_ok) - LW'(pull_ok);
      txover_d = (bus.sys_push & full & !bus.fsm_pull) | (txover_q & !bus.txover_clr);
      join_d   = bus.join_mode;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         level_q  <= '0;
         txover_q <= 1'b0;
         join_q   <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         level_q  <= level_d;
         txover_q <= txover_d;
         join_q   <= join_d;
      end
   always_ff @(posedge clk)
      if (push_ok && !clr) mem_q[wptr_q] <= bus.sys_wdata;
   assign bus.fsm_rdata = mem_q[rptr_q];
   assign bus.fsm_stall = bus.fsm_pull & empty;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.level     = level_q;
   assign bus.txover    = txover_q;
endmodule

// File: doc/tx_fifo.md
TX_FIFO -- requirements
Module: tx_fifo

Interface
REQ-001 Parameter WIDTH, default 32, data word width.
REQ-002 Parameter DEPTH, default 4, unjoined capacity in words; power of two.
REQ-003 clk  input  1  clock; all state on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sys_push  input  1  system write strobe; one word per cycle.
REQ-006 sys_wdata  input  WIDTH  word written on sys_push.
REQ-007 fsm_pull  input  1  state machine PULL request; consumes head word.
REQ-008 fsm_rdata  output  WIDTH  head word, show-ahead; valid when empty=0.
REQ-009 fsm_stall  output  1  combinational: fsm_pull & empty; tells the state machine to hold its pc.
REQ-010 join  input  1  1 = capacity 2*DEPTH, 0 = capacity DEPTH.
REQ-011 flush  input  1  synchronous clear of contents.
REQ-012 full  output  1  level == current capacity.
REQ-013 empty  output  1  level == 0.
REQ-014 level  output  clog2(2*DEPTH)+1  word count, 0..capacity.
REQ-015 txover  output  1  sticky overflow flag.
REQ-016 txover_clr  input  1  clears txover.

Function
REQ-017 Storage of 2*DEPTH words, circular write and read pointers of clog2(2*DEPTH) bits that wrap modulo 2*DEPTH; only capacity words usable at a time.
REQ-018 Push accepted when sys_push & (!full | fsm_pull); word written at wptr, wptr+1 next cycle.
REQ-019 Pull accepted when fsm_pull & !empty; rptr+1 next cycle; fsm_rdata reflects the new head the cycle after.
REQ-020 Push and pull accepted together: level unchanged, both pointers advance.
REQ-021 Full with simultaneous push and pull: both accepted, no overflow.
REQ-022 Empty with simultaneous push and pull: push accepted, pull rejected (no bypass), fsm_stall=1.
REQ-023 Push rejected when full and no pull: data dropped, contents unchanged, txover set next cycle.
REQ-024 txover_clr clears txover next cycle; a simultaneous overflow wins (txover stays 1).
REQ-025 Empty with a pull and no push: no state change; fsm_stall=1.
REQ-026 fsm_rdata while empty is don't-care; the bench does not check it.
REQ-027 flush: pointers and level to 0 next cycle; flush overrides a same-cycle push and pull; txover is unaffected.
REQ-028 Any change of join (sampled on posedge, compared to a registered copy) acts as flush in that cycle.
REQ-029 full, empty and level are registered-state derived (no combinational path from push/pull); latency push-to-not-empty 1 cycle.

Reset
REQ-030 rst: wptr=0, rptr=0, level=0, txover=0, registered join copy=0; thus empty=1, full=0 and fsm_stall=fsm_pull.
REQ-031 Storage array is not reset; rst mid-operation discards all words immediately.

Structure
REQ-032 WIDTH/DEPTH defaults and the level-width expression go in the shared PIO package with the state machine's constants.
REQ-033 Single module; the storage array is an inline register array; no sub-module.
REQ-034 rx_fifo reuses this block with push and pull roles swapped; nothing state-machine specific goes inside.

Verification
REQ-035 Reset, push 0xA5A5_0001..0xA5A5_0004 on consecutive cycles -> full=1, level=4; pulls return the same order; empty=1 after the 4th pull.
REQ-036 Full (4 words), push 0xDEAD_BEEF without pull -> txover=1, level=4, contents unchanged; txover_clr -> txover=0 next cycle.
REQ-037 Full, push 0x1234 with simultaneous pull -> txover=0, level=4, 0x1234 read out last.
REQ-038 Empty, push 0x55 with pull -> fsm_stall=1 that cycle, level=1 next cycle, next pull returns 0x55.
REQ-039 join=1: 8 pushes -> full=1 only after the 8th; toggle join -> level=0 next cycle; 20 push/pull pairs exercise pointer wrap with data matching.
REQ-040 Assert rst asynchronously with level=3 -> level=0, empty=1 and txover=0 before the next clock edge.
